// File: rtl/conv_ifm_feed_ctrl.sv
// Input-feature-map feed sequencer: requests pixel rows from the host, fills the
// circular line buffer and paces the conv engine one output row at a time per channel.
//
// state    | meaning
// IDLE     | waiting for start
// REQ      | need_pic raised, waiting for host ack
// LOAD     | accepting pixels into the line buffer
// COMPUTE  | one-cycle engine kick for out_row
// WAIT_ENG | waiting for eng_row_done
// NEXT_CH  | channel finished, advance or finish
// DONE     | one-cycle done pulse
module conv_ifm_feed_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IFM_SIZE   = 28,
  parameter int KSIZE      = 5,
  parameter int PADDING    = 4,
  parameter int CH_WIDTH   = 4
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic                        start,
  input  logic [CH_WIDTH-1:0]         num_ch,
  input  logic                        abort,
  output logic                        need_pic,
  input  logic                        need_pic_ack,
  input  logic                        pix_valid,
  input  logic [DATA_WIDTH-1:0]       pix_data,
  output logic                        pix_ready,
  output logic                        lb_wr_en,
  output logic [DATA_WIDTH-1:0]       lb_wr_data,
  output logic [$clog2(KSIZE)-1:0]    lb_row,
  output logic [$clog2(IFM_SIZE)-1:0] lb_col,
  output logic                        eng_start_row,
  output logic                        eng_pad_bot,
  output logic [$clog2(IFM_SIZE)-1:0] out_row,
  input  logic                        eng_row_done,
  output logic [CH_WIDTH-1:0]         ch_idx,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int PRE   = KSIZE - PADDING / 2;
  localparam int NLOAD = IFM_SIZE - PRE;
  localparam int NPAD  = PADDING / 2;
  localparam int RW    = $clog2(KSIZE);
  localparam int CW    = $clog2(IFM_SIZE);
  localparam int PW    = $clog2(PRE * IFM_SIZE);
  localparam int LW    = $clog2(NLOAD + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_LOAD, S_COMPUTE, S_WAIT_ENG, S_NEXT_CH, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CH_WIDTH-1:0]   num_q, num_d;
  logic [CH_WIDTH-1:0]   ch_idx_q, ch_idx_d;
  logic [CW-1:0]         out_row_q, out_row_d;
  logic [RW-1:0]         wr_row_q, wr_row_d;
  logic [CW-1:0]         wr_col_q, wr_col_d;
  logic [PW-1:0]         pix_left_q, pix_left_d;
  logic [LW-1:0]         loads_left_q, loads_left_d;
  logic                  err_q, err_d;
  logic                  need_pic_q, need_pic_d;
  logic                  pix_ready_q, pix_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  eng_start_q, eng_start_d;
  logic                  eng_pad_q, eng_pad_d;
  logic                  lb_wr_en_q, lb_wr_en_d;
  logic [DATA_WIDTH-1:0] lb_wr_data_q, lb_wr_data_d;
  logic [RW-1:0]         lb_row_q, lb_row_d;
  logic [CW-1:0]         lb_col_q, lb_col_d;

  logic accept;

  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    ch_idx_d     = ch_idx_q;
    out_row_d    = out_row_q;
    wr_row_d     = wr_row_q;
    wr_col_d     = wr_col_q;
    pix_left_d   = pix_left_q;
    loads_left_d = loads_left_q;
    err_d        = err_q;
    lb_wr_en_d   = 1'b0;
    lb_wr_data_d = lb_wr_data_q;
    lb_row_d     = lb_row_q;
    lb_col_d     = lb_col_q;
    accept       = pix_valid && pix_ready_q;

    // Pixels offered while not ready are dropped and flagged.
    if (pix_valid && !pix_ready_q) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d        = (num_ch == '0) ? CH_WIDTH'(1) : num_ch;
          err_d        = 1'b0;
          ch_idx_d     = '0;
          out_row_d    = '0;
          wr_row_d     = '0;
          wr_col_d     = '0;
          lb_row_d     = '0;
          lb_col_d     = '0;
          loads_left_d = LW'(NLOAD);
          state_d      = S_REQ;
        end
      end
      S_REQ: begin
        if (need_pic_ack) begin
          pix_left_d = (out_row_q == '0) ? PW'(PRE * IFM_SIZE - 1) : PW'(IFM_SIZE - 1);
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          lb_wr_en_d   = 1'b1;
          lb_wr_data_d = pix_data;
          lb_row_d     = wr_row_q;
          lb_col_d     = wr_col_q;
          if (wr_col_q == CW'(IFM_SIZE - 1)) begin
            wr_col_d = '0;
            wr_row_d = (wr_row_q == RW'(KSIZE - 1)) ? '0 : wr_row_q + RW'(1);
          end else begin
            wr_col_d = wr_col_q + CW'(1);
          end
          if (pix_left_q == '0) begin
            // The preload (out_row 0) does not count against the per-row loads.
            if (out_row_q != '0) loads_left_d = loads_left_q - LW'(1);
            state_d = S_COMPUTE;
          end else begin
            pix_left_d = pix_left_q - PW'(1);
          end
        end
      end
      S_COMPUTE: state_d = S_WAIT_ENG;
      S_WAIT_ENG: begin
        if (eng_row_done) begin
          if (out_row_q == CW'(IFM_SIZE - 1)) begin
            state_d = S_NEXT_CH;
          end else begin
            out_row_d = out_row_q + CW'(1);
            state_d   = (loads_left_q != '0) ? S_REQ : S_COMPUTE;
          end
        end
      end
      S_NEXT_CH: begin
        if (ch_idx_q == num_q - CH_WIDTH'(1)) begin
          state_d = S_DONE;
        end else begin
          ch_idx_d     = ch_idx_q + CH_WIDTH'(1);
          out_row_d    = '0;
          wr_row_d     = '0;
          wr_col_d     = '0;
          lb_row_d     = '0;
          lb_col_d     = '0;
          loads_left_d = LW'(NLOAD);
          state_d      = S_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d    = S_IDLE;
      lb_wr_en_d = 1'b0;
    end

    need_pic_d  = (state_d == S_REQ);
    pix_ready_d = (state_d == S_LOAD);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    eng_start_d = (state_d == S_COMPUTE);
    eng_pad_d   = (state_d == S_COMPUTE) && (out_row_d >= CW'(IFM_SIZE - NPAD));
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= S_IDLE;
      num_q        <= '0;
      ch_idx_q     <= '0;
      out_row_q    <= '0;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      pix_left_q   <= '0;
      loads_left_q <= '0;
      err_q        <= 1'b0;
      need_pic_q   <= 1'b0;
      pix_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      eng_start_q  <= 1'b0;
      eng_pad_q    <= 1'b0;
      lb_wr_en_q   <= 1'b0;
      lb_wr_data_q <= '0;
      lb_row_q     <= '0;
      lb_col_q     <= '0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      ch_idx_q     <= ch_idx_d;
      out_row_q    <= out_row_d;
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      pix_left_q   <= pix_left_d;
      loads_left_q <= loads_left_d;
      err_q        <= err_d;
      need_pic_q   <= need_pic_d;
      pix_ready_q  <= pix_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      eng_start_q  <= eng_start_d;
      eng_pad_q    <= eng_pad_d;
      lb_wr_en_q   <= lb_wr_en_d;
      lb_wr_data_q <= lb_wr_data_d;
      lb_row_q     <= lb_row_d;
      lb_col_q     <= lb_col_d;
    end
  end

  assign need_pic      = need_pic_q;
  assign pix_ready     = pix_ready_q;
  assign lb_wr_en      = lb_wr_en_q;
  assign lb_wr_data    = lb_wr_data_q;
  assign lb_row        = lb_row_q;
  assign lb_col        = lb_col_q;
  assign eng_start_row = eng_start_q;
  assign eng_pad_bot   = eng_pad_q;
  assign out_row       = out_row_q;
  assign ch_idx        = ch_idx_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_conv_ifm_feed_ctrl.sv
// Directed bench for conv_ifm_feed_ctrl: host and engine models, write scoreboard,
// preload/wrap boundaries, multi-channel, error, abort and reset scenarios.
module tb_conv_ifm_feed_ctrl;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic       start = 1'b0;
  logic [3:0] num_ch = '0;
  logic       abort = 1'b0;
  logic       need_pic;
  logic       need_pic_ack = 1'b0;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_data = '0;
  logic       pix_ready;
  logic       lb_wr_en;
  logic [7:0] lb_wr_data;
  logic [2:0] lb_row;
  logic [4:0] lb_col;
  logic       eng_start_row;
  logic       eng_pad_bot;
  logic [4:0] out_row;
  logic       eng_row_done = 1'b0;
  logic [3:0] ch_idx;
  logic       busy;
  logic       done;
  logic       err;

  conv_ifm_feed_ctrl dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .num_ch(num_ch), .abort(abort),
    .need_pic(need_pic), .need_pic_ack(need_pic_ack), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_ready(pix_ready), .lb_wr_en(lb_wr_en),
    .lb_wr_data(lb_wr_data), .lb_row(lb_row), .lb_col(lb_col),
    .eng_start_row(eng_start_row), .eng_pad_bot(eng_pad_bot), .out_row(out_row),
    .eng_row_done(eng_row_done), .ch_idx(ch_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [7:0] d;
    logic [2:0] r;
    logic [4:0] c;
  } wr_t;

  wr_t sb[$];
  int  n_tests = 0, n_fail = 0;
  int  n_wr = 0, n_need = 0, n_eng = 0, n_pad = 0, n_done = 0;
  int  done_eng = 0, done_ch = 0;
  int  gpix = 0, pix_limit = 0, wr_idx = 0, exp_row = 0, exp_ch = 0, eng_delay = 0;
  int  w139_r = 0, w139_c = 0, w140_r = 0, w140_c = 0;
  bit  host_auto = 1'b0, eng_auto = 1'b0;
  logic need_prev = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: sample DUT at the falling edge, then drive host/engine inputs.
  task automatic tick();
    wr_t e;
    @(negedge HCLK);
    if (lb_wr_en) begin
      if (sb.size() == 0) begin
        chk("unexpected lb_wr_en", int'(lb_wr_en), 0);
      end else begin
        e = sb.pop_front();
        chk("lb_wr_data", int'(lb_wr_data), int'(e.d));
        chk("lb_row", int'(lb_row), int'(e.r));
        chk("lb_col", int'(lb_col), int'(e.c));
      end
      if (wr_idx % 784 == 139) begin w139_r = int'(lb_row); w139_c = int'(lb_col); end
      if (wr_idx % 784 == 140) begin w140_r = int'(lb_row); w140_c = int'(lb_col); end
      n_wr++;
      wr_idx++;
    end
    if (need_pic && !need_prev) n_need++;
    need_prev = need_pic;
    if (done) begin n_done++; done_eng = n_eng; done_ch = int'(ch_idx); end

    eng_row_done = 1'b0;
    if (eng_delay != 0) begin
      eng_delay--;
      if (eng_delay == 0) eng_row_done = 1'b1;
    end
    if (eng_start_row) begin
      chk("out_row", int'(out_row), exp_row);
      chk("eng_pad_bot", int'(eng_pad_bot), (exp_row >= 26) ? 1 : 0);
      chk("ch_idx", int'(ch_idx), exp_ch);
      if (exp_row == 0) chk("preload pixel count", gpix - 784 * exp_ch, 84);
      if (eng_pad_bot) n_pad++;
      n_eng++;
      if (eng_auto) eng_delay = 3;
      if (exp_row == 27) begin exp_row = 0; exp_ch++; end
      else exp_row++;
    end

    need_pic_ack = 1'b0;
    pix_valid    = 1'b0;
    if (host_auto) begin
      if (need_pic) need_pic_ack = 1'b1;
      if (pix_ready && gpix < pix_limit) begin
        pix_valid = 1'b1;
        pix_data  = 8'(gpix * 7 + 3);
        e.d = pix_data;
        e.r = 3'(((gpix % 784) / 28) % 5);
        e.c = 5'(gpix % 28);
        sb.push_back(e);
        gpix++;
      end
    end
  endtask

  task automatic start_job(input int n);
    gpix = 0; wr_idx = 0; exp_row = 0; exp_ch = 0; eng_delay = 0;
    w139_r = 7; w139_c = 31; w140_r = 7; w140_c = 31;
    sb.delete();
    num_ch = 4'(n);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    num_ch = '0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int b = n_done;
    for (int i = 0; i < budget && n_done == b; i++) tick();
    chk(tag, (n_done != b) ? 1 : 0, 1);
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, " need_pic"}, int'(need_pic), 0);
    chk({tag, " pix_ready"}, int'(pix_ready), 0);
    chk({tag, " lb_wr_en"}, int'(lb_wr_en), 0);
    chk({tag, " lb_wr_data"}, int'(lb_wr_data), 0);
    chk({tag, " lb_row"}, int'(lb_row), 0);
    chk({tag, " lb_col"}, int'(lb_col), 0);
    chk({tag, " eng_start_row"}, int'(eng_start_row), 0);
    chk({tag, " eng_pad_bot"}, int'(eng_pad_bot), 0);
    chk({tag, " out_row"}, int'(out_row), 0);
    chk({tag, " ch_idx"}, int'(ch_idx), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " err"}, int'(err), 0);
  endtask

  task automatic run_full(input string tag, input int n);
    int b_need = n_need, b_wr = n_wr, b_eng = n_eng, b_pad = n_pad, b_done = n_done;
    host_auto = 1'b1;
    eng_auto  = 1'b1;
    pix_limit = 1 << 30;
    start_job(n);
    wait_done({tag, " done reached"}, 6000 * n);
    repeat (3) tick();
    chk({tag, " need_pic rises"}, n_need - b_need, 26 * n);
    chk({tag, " lb writes"}, n_wr - b_wr, 784 * n);
    chk({tag, " eng starts"}, n_eng - b_eng, 28 * n);
    chk({tag, " pad rows"}, n_pad - b_pad, 2 * n);
    chk({tag, " done pulses"}, n_done - b_done, 1);
    chk({tag, " eng starts before done"}, done_eng - b_eng, 28 * n);
    chk({tag, " ch_idx at done"}, done_ch, n - 1);
    chk({tag, " busy after"}, int'(busy), 0);
    chk({tag, " scoreboard drained"}, sb.size(), 0);
    chk({tag, " wrap-1 lb_row"}, w139_r, 4);
    chk({tag, " wrap-1 lb_col"}, w139_c, 27);
    chk({tag, " wrap lb_row"}, w140_r, 0);
    chk({tag, " wrap lb_col"}, w140_c, 0);
  endtask

  initial begin
    int b;

    // Reset state
    tick();
    tick();
    outputs_zero("reset");
    HRESETn = 1'b1;
    tick();
    outputs_zero("after release");

    run_full("single ch", 1);

    // Preload boundary: 83 pixels hold in LOAD, the 84th kicks row 0
    b = n_wr;
    host_auto = 1'b1; eng_auto = 1'b1; pix_limit = 83;
    start_job(1);
    for (int i = 0; i < 2000 && n_wr - b < 83; i++) tick();
    chk("83 pixels written", n_wr - b, 83);
    b = n_eng;
    repeat (3) tick();
    chk("83 pix_ready", int'(pix_ready), 1);
    chk("83 no eng start", n_eng - b, 0);
    pix_limit = 84;
    b = n_wr - 83;
    for (int i = 0; i < 20 && n_wr - b < 84; i++) tick();
    chk("84th pixel written", n_wr - b, 84);
    chk("84 pix_ready low", int'(pix_ready), 0);
    chk("84 eng_start_row", int'(eng_start_row), 1);
    pix_limit = 1 << 30;
    wait_done("preload job done", 6000);
    repeat (3) tick();

    run_full("three ch", 3);

    // Error and ignored ack, then abort mid-load
    host_auto = 1'b0; eng_auto = 1'b1; pix_limit = 40;
    start_job(1);
    for (int i = 0; i < 10 && !need_pic; i++) tick();
    chk("req need_pic", int'(need_pic), 1);
    b = n_wr;
    pix_valid = 1'b1;
    pix_data  = 8'hEE;
    tick();
    chk("req pixel err", int'(err), 1);
    tick();
    chk("req pixel no write", n_wr - b, 0);
    chk("req still need_pic", int'(need_pic), 1);
    need_pic_ack = 1'b1;
    tick();
    chk("ack enters load", int'(pix_ready), 1);
    chk("ack drops need_pic", int'(need_pic), 0);
    need_pic_ack = 1'b1;
    tick();
    tick();
    chk("load ack ignored ready", int'(pix_ready), 1);
    chk("load ack ignored need_pic", int'(need_pic), 0);
    host_auto = 1'b1;
    b = n_wr;
    for (int i = 0; i < 200 && n_wr - b < 40; i++) tick();
    chk("40 pixels written", n_wr - b, 40);
    tick();
    b = n_done;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort busy", int'(busy), 0);
    chk("abort pix_ready", int'(pix_ready), 0);
    chk("abort need_pic", int'(need_pic), 0);
    chk("abort err kept", int'(err), 1);
    repeat (10) tick();
    chk("abort no done", n_done - b, 0);
    chk("abort stays idle", int'(busy), 0);

    // Start clears err; reset while the engine is busy
    host_auto = 1'b1; eng_auto = 1'b0; pix_limit = 1 << 30;
    start_job(1);
    chk("start clears err", int'(err), 0);
    b = n_eng;
    for (int i = 0; i < 500 && n_eng == b; i++) tick();
    chk("first row kicked", n_eng - b, 1);
    repeat (3) tick();
    chk("waiting on engine", int'(busy), 1);
    b = n_done;
    HRESETn = 1'b0;
    #1;
    outputs_zero("async reset");
    tick();
    HRESETn = 1'b1;
    tick();
    chk("reset no done", n_done - b, 0);
    sb.delete();

    run_full("after reset", 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_ifm_feed_ctrl.md
Name: conv_ifm_feed_ctrl

Overview:
Sequencing controller between the APB register file of the convolution wrapper and the line-buffer/conv engine. It runs the per-channel input-feature-map schedule for a padded KSIZE×KSIZE convolution:
- raise need_pic to the host;
- accept a preload burst of (KSIZE−PADDING/2) rows, then one row per request;
- trigger one output-row computation after each load;
- run the bottom-padding rows without new input;
- repeat for NUM channels.

Parameters:
DATA_WIDTH, 8, pixel width
IFM_SIZE, 28, IFM rows = columns = output rows
KSIZE, 5, kernel size; also the number of line-buffer rows
PADDING, 4, total padding (PADDING/2 per side)
CH_WIDTH, 4, width of the channel count

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
start  in  1  pulse; latches num_ch, clears err
num_ch  in  CH_WIDTH  channels to process; 0 is treated as 1
abort  in  1  return to IDLE
need_pic  out  1  host request for pixels
need_pic_ack  in  1  host acknowledge (APB write 0x4)
pix_valid  in  1  pixel strobe (APB write 0x8)
pix_data  in  DATA_WIDTH  pixel value
pix_ready  out  1  controller accepts pixels
lb_wr_en  out  1  line-buffer write
lb_wr_data  out  DATA_WIDTH  line-buffer data
lb_row  out  clog2(KSIZE)  circular line-buffer row
lb_col  out  clog2(IFM_SIZE)  column
eng_start_row  out  1  pulse: compute one output row
eng_pad_bot  out  1  qualifies eng_start_row as a bottom-pad row
out_row  out  clog2(IFM_SIZE)  output row index being computed
eng_row_done  in  1  engine finished the row
ch_idx  out  CH_WIDTH  current channel
busy  out  1  not IDLE
done  out  1  one-cycle pulse at end of job
err  out  1  sticky: pixel offered while pix_ready=0

Behaviour:
- Reset (async, HRESETn=0):
  - State IDLE.
  - All outputs 0; all counters 0.
  - Asserting reset mid-operation aborts immediately, with no done.
- Constants:
  - PRE = KSIZE−PADDING/2 = 3
  - NLOAD = IFM_SIZE−PRE = 25
  - NPAD = PADDING/2 = 2
- States: IDLE, REQ, LOAD, COMPUTE, WAIT_ENG, NEXT_CH, DONE.
- IDLE:
  - start=1 latches num_ch (0→1).
  - Clears err, ch_idx, out_row, lb_row, lb_col, and the load counter.
  - Next state REQ.
  - start while busy is ignored.
- REQ:
  - need_pic=1, registered: high in the cycle after entry.
  - Held until need_pic_ack is sampled 1.
  - Next state LOAD; need_pic falls in the same edge.
  - need_pic_ack outside REQ is ignored.
- LOAD:
  - pix_ready=1.
  - Target = PRE×IFM_SIZE pixels for the first load of a channel, IFM_SIZE for later loads.
  - Each pix_valid&&pix_ready cycle registers lb_wr_en=1 with pix_data, lb_row and lb_col on the next cycle (1-cycle latency).
  - lb_col increments and wraps at IFM_SIZE−1; on that wrap lb_row increments mod KSIZE.
  - On the last pixel of the target: pix_ready drops in the next cycle, then go to COMPUTE.
- COMPUTE:
  - One-cycle eng_start_row with current out_row.
  - eng_pad_bot=1 iff out_row ≥ IFM_SIZE−NPAD.
  - Next state WAIT_ENG.
- WAIT_ENG, on eng_row_done=1:
  - If out_row=IFM_SIZE−1: go to NEXT_CH.
  - Otherwise increment out_row.
  - If fewer than NLOAD per-row loads are done: go to REQ.
  - Otherwise go to COMPUTE (pad rows, no need_pic).
  - eng_row_done in other states is ignored.
- NEXT_CH:
  - If ch_idx = num_ch−1: go to DONE.
  - Otherwise increment ch_idx, clear out_row, lb_row, lb_col and the load counter, go to REQ.
- DONE: done=1 for one cycle, then IDLE.
- Per channel totals: 1+NLOAD = 26 requests, 784 writes, 28 eng_start_row (last 2 pad).
- err: pix_valid while pix_ready=0 sets err. The pixel is dropped, with no lb write and no counter change.
- abort (any state, priority over all else):
  - Next cycle IDLE.
  - need_pic, pix_ready, busy low.
  - No done; err unchanged.
- busy = (state ≠ IDLE), registered.

Test Plan:
- Single channel: num_ch=1, start; bench acks every need_pic, feeds pixels=1, engine model returns eng_row_done 3 cycles after eng_start_row. Required:
  - 26 need_pic rises;
  - 784 lb_wr_en;
  - 28 eng_start_row with out_row 0..27, eng_pad_bot=1 only on rows 26, 27;
  - exactly one done;
  - busy=0 after.
- Preload boundary: feed 83 pixels → no eng_start_row, pix_ready=1. 84th pixel → pix_ready=0 next cycle; eng_start_row with out_row=0 follows.
- Line-buffer wrap: the 141st pixel (row 5, col 0) is written with lb_row=0, lb_col=0; the pixel before it has lb_row=4, lb_col=27.
- Three channels: num_ch=3 → ch_idx 0,1,2; 78 need_pic total; each channel restarts with an 84-pixel load; done only after ch_idx=2 completes.
- Error and ignore: pix_valid during REQ → err=1, no lb write; need_pic_ack in LOAD → no effect; next start clears err.
- Abort/reset: abort after 40 LOAD pixels → IDLE next cycle, no done. HRESETn pulse during WAIT_ENG → all outputs 0 immediately. A fresh start then completes scenario 1 unchanged.
